// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows a 32-bit store to byte/halfword/word lanes,
// issues one word-aligned memory write over a valid/ack handshake and
// reports whether the value survives sign extension from the access size.
module store_narrow_unit #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  output logic        mem_valid,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        done,
  output logic        fits_signed,
  output logic        misaligned,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE, ERR} state_t;

  localparam logic [7:0] LIMIT = 8'(ACK_TIMEOUT - 1);

  state_t      state, state_nx;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        fits_q;
  logic [7:0]  cnt;
  logic        tmo_q;

  logic        legal;
  logic [31:0] wdata_d;
  logic [3:0]  be_d;
  logic        fits_d;
  logic        limit_hit;

  assign limit_hit = (cnt == LIMIT);

  // Decode the incoming request into lanes, enables, fit flag and legality.
  always_comb begin
    wdata_d = req_data;
    be_d    = 4'b1111;
    fits_d  = 1'b1;
    legal   = 1'b1;
    case (req_size)
      2'b00: begin
        wdata_d = {4{req_data[7:0]}};
        be_d    = 4'b0001 << req_addr[1:0];
        fits_d  = (&req_data[31:7]) | ~(|req_data[31:7]);
      end
      2'b01: begin
        wdata_d = {2{req_data[15:0]}};
        be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
        fits_d  = (&req_data[31:15]) | ~(|req_data[31:15]);
        legal   = ~req_addr[0];
      end
      2'b10: begin
        legal   = (req_addr[1:0] == 2'b00);
      end
      default: begin
        legal   = 1'b0;
      end
    endcase
  end

  // State register, request capture, ack-wait counter and timeout pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      tmo_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      fits_q  <= 1'b0;
    end else begin
      state <= state_nx;
      // Pulse lands in the IDLE cycle that follows the last unacked ISSUE cycle.
      tmo_q <= (state == ISSUE) && !mem_ack && limit_hit;
      if (state == IDLE && req_valid) begin
        addr_q  <= {req_addr[31:2], 2'b00};
        wdata_q <= wdata_d;
        be_q    <= be_d;
        fits_q  <= fits_d;
        cnt     <= '0;
      end else if (state == ISSUE && !mem_ack) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Next-state selection and state-decoded outputs.
  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    mem_valid   = 1'b0;
    done        = 1'b0;
    misaligned  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = reset_n;
        if (req_valid) state_nx = legal ? ISSUE : ERR;
      end
      ISSUE: begin
        mem_valid = 1'b1;
        if (mem_ack)        state_nx = DONE;
        else if (limit_hit) state_nx = IDLE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        misaligned = 1'b1;
        state_nx   = IDLE;
      end
    endcase
    mem_addr    = mem_valid ? addr_q  : '0;
    mem_wdata   = mem_valid ? wdata_q : '0;
    mem_be      = mem_valid ? be_q    : '0;
    fits_signed = done & fits_q;
    timeout     = tmo_q;
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: the driver plans each transaction, the
// transaction-level model derives the full per-cycle output timeline from the
// request and the chosen ack delay, and one compare process checks every cycle.
module tb_store_narrow_unit;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic        mem_valid;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        fits_signed;
  logic        misaligned;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  store_narrow_unit #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_size(req_size), .req_addr(req_addr),
    .mem_valid(mem_valid), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .done(done), .fits_signed(fits_signed),
    .misaligned(misaligned), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        mvalid;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        done;
    logic        fits;
    logic        mis;
    logic        tmo;
  } exp_t;

  exp_t q[$];

  // ---------------- reference model ----------------
  function automatic logic m_legal(logic [1:0] size, logic [31:0] addr);
    if (size == 2'd3) return 1'b0;
    return (addr % (32'd1 << size)) == 0;
  endfunction

  function automatic logic [31:0] m_wdata(logic [31:0] d, logic [1:0] size);
    case (size)
      2'd0:    return (d & 32'hFF) * 32'h01010101;
      2'd1:    return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] m_be(logic [1:0] size, logic [31:0] addr);
    case (size)
      2'd0:    return 4'(1 << (addr % 4));
      2'd1:    return ((addr % 4) >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic m_fits(logic [31:0] d, logic [1:0] size);
    int sd;
    sd = $signed(d);
    case (size)
      2'd0:    return (sd >= -128) && (sd <= 127);
      2'd1:    return (sd >= -32768) && (sd <= 32767);
      default: return 1'b1;
    endcase
  endfunction

  function automatic exp_t e_zero();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t e_idle();
    exp_t e;
    e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_issue(logic [31:0] a, logic [31:0] w, logic [3:0] b);
    exp_t e;
    e = '0;
    e.mvalid = 1'b1;
    e.maddr  = a & 32'hFFFF_FFFC;
    e.wdata  = w;
    e.be     = b;
    return e;
  endfunction

  function automatic exp_t e_done(logic f);
    exp_t e;
    e = '0;
    e.done = 1'b1;
    e.fits = f;
    return e;
  endfunction

  function automatic exp_t e_err();
    exp_t e;
    e = '0;
    e.mis = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_tmo();
    exp_t e;
    e = '0;
    e.ready = 1'b1;
    e.tmo   = 1'b1;
    return e;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Single compare process: every cycle with a planned expectation is checked.
  always @(negedge clk) begin
    exp_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{req_ready, mem_valid, mem_addr, mem_wdata, mem_be,
            done, fits_signed, misaligned, timeout};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle@%0t: got rdy=%b mv=%b addr=%h wd=%h be=%h dn=%b fs=%b mis=%b to=%b expected rdy=%b mv=%b addr=%h wd=%h be=%h dn=%b fs=%b mis=%b to=%b",
                 $time, a.ready, a.mvalid, a.maddr, a.wdata, a.be, a.done, a.fits, a.mis, a.tmo,
                 e.ready, e.mvalid, e.maddr, e.wdata, e.be, e.done, e.fits, e.mis, e.tmo);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Random request fields while the unit is busy; they must be ignored.
  task automatic junk(input bit hold);
    req_valid = hold ? 1'b1 : 1'($urandom % 2);
    req_data  = $urandom;
    req_size  = 2'($urandom);
    req_addr  = $urandom;
    mem_ack   = 1'($urandom % 2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0;
      req_data  = $urandom;
      mem_ack   = 1'($urandom % 2);
      step(e_idle());
    end
  endtask

  // ackdel: number of ISSUE cycles before the ack cycle; negative = never.
  task automatic txn(input logic [31:0] d, input logic [1:0] sz, input logic [31:0] a,
                     input int ackdel, input bit hold);
    logic [31:0] w;
    logic [3:0]  b;
    logic        f;
    req_valid = 1'b1;
    req_data  = d;
    req_size  = sz;
    req_addr  = a;
    mem_ack   = 1'($urandom % 2);
    step(e_idle());
    if (!m_legal(sz, a)) begin
      junk(hold);
      step(e_err());
      return;
    end
    w = m_wdata(d, sz);
    b = m_be(sz, a);
    f = m_fits(d, sz);
    for (int i = 1; i <= T; i++) begin
      junk(hold);
      mem_ack = (ackdel >= 0) && (i == ackdel + 1);
      step(e_issue(a, w, b));
      if (mem_ack) begin
        junk(hold);
        step(e_done(f));
        return;
      end
    end
    req_valid = 1'b0;
    mem_ack   = 1'($urandom % 2);
    step(e_tmo());
  endtask

  // Accept a word store, then pull reset in the k-th ISSUE cycle.
  task automatic txn_reset(input logic [31:0] d, input logic [31:0] a, input int k);
    req_valid = 1'b1;
    req_data  = d;
    req_size  = 2'd2;
    req_addr  = a;
    mem_ack   = 1'b0;
    step(e_idle());
    for (int i = 1; i <= k; i++) begin
      junk(1'b0);
      mem_ack = 1'b0;
      if (i == k) reset_n = 1'b0;
      step(e_issue(a, d, 4'hF));
    end
    junk(1'b0);
    step(e_zero());
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_data  = '0;
    req_size  = '0;
    req_addr  = '0;
    mem_ack   = 1'b0;

    // Model pins against hand-computed values.
    chk("pin_b_wdata", m_wdata(32'hFFFFFF80, 2'd0), 32'h80808080);
    chk("pin_b_be",    32'(m_be(2'd0, 32'h1003)), 32'h8);
    chk("pin_b_fits",  32'(m_fits(32'hFFFFFF80, 2'd0)), 32'h1);
    chk("pin_h_wdata", m_wdata(32'h00012345, 2'd1), 32'h23452345);
    chk("pin_h_be",    32'(m_be(2'd1, 32'h2002)), 32'hC);
    chk("pin_h_fits",  32'(m_fits(32'h00012345, 2'd1)), 32'h0);
    chk("pin_w_mis",   32'(m_legal(2'd2, 32'h3001)), 32'h0);
    chk("pin_rsv",     32'(m_legal(2'd3, 32'h3000)), 32'h0);

    @(posedge clk);
    #1;
    step(e_zero());
    reset_n = 1'b1;
    idle(2);

    txn(32'hFFFFFF80, 2'd0, 32'h0000_1003, 0, 1'b0);
    idle(1);
    txn(32'h00012345, 2'd1, 32'h0000_2002, 2, 1'b0);
    txn(32'h12345678, 2'd2, 32'h0000_3001, 0, 1'b0);
    txn(32'h12345678, 2'd3, 32'h0000_3000, 0, 1'b0);
    txn(32'hDEADBEEF, 2'd2, 32'h0000_4000, -1, 1'b0);
    txn(32'h0000007F, 2'd0, 32'h0000_5001, 14, 1'b0);
    txn(32'hFFFF8000, 2'd1, 32'h0000_5000, 15, 1'b0);
    txn_reset(32'hCAFEF00D, 32'h0000_6000, 3);
    idle(1);
    for (int i = 0; i < 4; i++)
      txn($urandom, 2'd2, 32'h0000_7000 + 32'(i * 4), 0, 1'b1);
    idle(3);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] d, a;
      logic [1:0]  sz;
      int          ad, pick;
      pick = int'($urandom % 4);
      d = (pick == 0) ? 32'($signed(8'($urandom))) :
          (pick == 1) ? 32'($signed(16'($urandom))) :
          (pick == 2) ? ($urandom % 256) : $urandom;
      sz = 2'($urandom);
      a  = $urandom;
      if ($urandom % 4 != 0) a = a & ~((32'd1 << sz) - 1);
      pick = int'($urandom % 10);
      ad = (pick < 7) ? int'($urandom % 5) : (pick == 7) ? 14 : (pick == 8) ? -1 : 15;
      if ($urandom % 16 == 0) txn_reset(d, a & 32'hFFFF_FFFC, 1 + int'($urandom % 5));
      else                    txn(d, sz, a, ad, 1'($urandom % 2));
      if ($urandom % 3 == 0) idle(1 + int'($urandom % 2));
    end

    idle(2);
    @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_narrow_unit.md
# store_narrow_unit

Store-side data narrowing unit for the MIPS datapath, the counterpart of the 16→32 sign extender on the load/immediate path. It accepts a 32-bit register value, access size and byte address from the execute stage, then issues one word-aligned write with byte enables to data memory over a valid/ack handshake. It also reports whether the value round-trips through sign extension unchanged (`fits_signed`), so the same value would be read back by a signed load. Misaligned and reserved-size requests are rejected without touching memory.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 15: maximum number of cycles spent in ISSUE without `mem_ack` before the access is aborted (legal range 1–255).

Ports:
- `clk`  in  1  single clock; all logic samples on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_data`  in  32  register value to store.
- `req_size`  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- `req_addr`  in  32  byte address.
- `mem_valid`  out  1  write request to memory.
- `mem_ack`  in  1  memory accepted the write.
- `mem_addr`  out  32  `{req_addr[31:2], 2'b00}`.
- `mem_wdata`  out  32  lane-replicated write data.
- `mem_be`  out  4  byte enables; bit i = byte lane i, little-endian.
- `done`  out  1  one-cycle pulse on successful completion.
- `fits_signed`  out  1  valid only while `done`=1.
- `misaligned`  out  1  one-cycle pulse on a rejected request.
- `timeout`  out  1  one-cycle pulse on an aborted access.

## Operation
- States: IDLE, ISSUE, DONE, ERR.
- IDLE: `req_ready`=1. A request is accepted when `req_valid`=1; the unit registers data, size, address, lanes, enables and `fits_signed`.
  - Legal request → ISSUE.
  - Illegal request → ERR. Illegal means: size 11; halfword with `addr[0]`=1; word with `addr[1:0]`≠00.
- ISSUE: `mem_valid`=1 and the memory outputs are held stable. `mem_ack`=1 → DONE. Otherwise the cycle counter increments; when it reaches `ACK_TIMEOUT` the unit pulses `timeout`, drops `mem_valid` and returns to IDLE. If `mem_ack` arrives in the same cycle the limit is reached, the ack wins and the unit goes to DONE.
- DONE: `done`=1 and `fits_signed` is presented → IDLE.
- ERR: `misaligned`=1; no memory access is made → IDLE.
- `mem_ack` is ignored outside ISSUE.
- Lane rules:
  - byte: `wdata`={4{data[7:0]}}, `be`=0001<<addr[1:0].
  - half: `wdata`={2{data[15:0]}}, `be`=0011 if addr[1]=0, else 1100.
  - word: `wdata`=data, `be`=1111.
- `fits_signed`:
  - byte: `data[31:7]` all equal.
  - half: `data[31:15]` all equal.
  - word: 1.
- A non-fitting value is still stored (truncated); the flag is informational only.

## Timing
- Reset (`reset_n`=0 at a rising edge): state IDLE, counter 0. All outputs are 0 except `req_ready`=1 once reset is released. Reset mid-ISSUE aborts the access immediately; no `done` or `timeout` pulse is produced.
- Request accepted at edge N → `mem_valid`=1 from cycle N+1.
- `mem_ack` sampled high at edge M → `done` high during cycle M+1, `req_ready` high at M+2.
- Best case: 3 cycles from acceptance to the next acceptance.
- Illegal request accepted at N → `misaligned` high in cycle N+1, IDLE at N+2.
- Timeout: `timeout` pulses in the cycle after the `ACK_TIMEOUT`-th unacknowledged ISSUE cycle.
- Only one request is outstanding at a time; there is no pipelining.

## Test plan
- Byte store, data=0xFFFFFF80, addr=0x1003, size 00 → `mem_addr`=0x1000, `be`=1000, `wdata`=0x80808080, `done` with `fits_signed`=1.
- Halfword store, data=0x00012345, addr=0x2002, ack after 2 cycles → `be`=1100, `wdata`=0x23452345, `fits_signed`=0, `done` one cycle after ack.
- Word store to 0x3001, and size=11 at 0x3000 → `misaligned` pulse each, `mem_valid` never asserted.
- Word store, data=0xDEADBEEF, no ack, `ACK_TIMEOUT`=15 → `mem_valid` high for 15 cycles, then `timeout` pulse, `req_ready`=1 on the next cycle.
- Ack arriving on the 15th ISSUE cycle → `done`, no `timeout`. Separately, `reset_n`=0 asserted during ISSUE → all outputs 0 on the next cycle, no pulses.
- Back-to-back requests with `req_valid` held high → second request accepted only when `req_ready`=1. A spurious `mem_ack` in IDLE has no effect.
